ibex_wb_result_stage: RTL and testbench

// - Writeback stage directly downstream of the execute block.
// - Captures each completing instruction's EX result (or pending load) in a one-entry holding register.
// - Drives the register-file write port one cycle later, or on arrival of the LSU load response.
// - Provides forwarding data to ID and an optional load-response timeout.

---
 rtl/ibex_wb_result_stage.sv | 139 +++++++++++++
 tb/tb_ibex_wb_result_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ibex_wb_result_stage.sv
// Writeback result stage: holds one completing instruction and drives the register-file write port,
// either from the held EX result or from the LSU load response, with an optional load timeout.
module ibex_wb_result_stage #(
  parameter int unsigned LsuTimeout = 0,
  parameter int unsigned CntWidth   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_wb_i,
  input  logic        instr_is_load_i,
  input  logic        rf_we_i,
  input  logic [4:0]  rf_waddr_i,
  input  logic [31:0] rf_wdata_i,
  output logic        ready_wb_o,
  input  logic        lsu_resp_valid_i,
  input  logic [31:0] lsu_rdata_i,
  input  logic        lsu_resp_err_i,
  output logic        rf_we_wb_o,
  output logic [4:0]  rf_waddr_wb_o,
  output logic [31:0] rf_wdata_wb_o,
  output logic        fwd_valid_o,
  output logic        instr_done_wb_o,
  output logic        load_err_o,
  output logic        load_timeout_o
);

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_RESULT = 2'd1,
    WB_LOAD   = 2'd2
  } wb_state_e;

  localparam bit                TimeoutEn = (LsuTimeout != 0);
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(LsuTimeout);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(LsuTimeout - 1);

  wb_state_e             state_q, state_d;
  logic                  we_q, we_d;
  logic [4:0]            waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;

  logic in_load;
  logic resp_hit;
  logic timeout_hit;
  logic accept;

  always_comb begin
    in_load     = (state_q == WB_LOAD);
    resp_hit    = in_load & lsu_resp_valid_i;
    // A response on the same cycle as the last wait cycle takes priority over the timeout.
    timeout_hit = TimeoutEn & in_load & ~lsu_resp_valid_i & (cnt_q == CntLast);
    ready_wb_o  = ~in_load | lsu_resp_valid_i | timeout_hit;
    accept      = en_wb_i & ready_wb_o;
  end

  always_comb begin
    rf_we_wb_o      = 1'b0;
    rf_waddr_wb_o   = waddr_q;
    rf_wdata_wb_o   = wdata_q;
    fwd_valid_o     = 1'b0;
    instr_done_wb_o = 1'b0;
    load_err_o      = 1'b0;
    load_timeout_o  = 1'b0;
    unique case (state_q)
      WB_RESULT: begin
        rf_we_wb_o      = we_q;
        fwd_valid_o     = we_q;
        instr_done_wb_o = 1'b1;
      end
      WB_LOAD: begin
        rf_wdata_wb_o = lsu_rdata_i;
        if (resp_hit) begin
          rf_we_wb_o      = we_q & ~lsu_resp_err_i;
          fwd_valid_o     = we_q & ~lsu_resp_err_i;
          instr_done_wb_o = 1'b1;
          load_err_o      = lsu_resp_err_i;
        end else if (timeout_hit) begin
          instr_done_wb_o = 1'b1;
          load_timeout_o  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      WB_RESULT: state_d = WB_IDLE;
      WB_LOAD: begin
        if (resp_hit || timeout_hit) begin
          state_d = WB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = WB_IDLE;
    endcase

    // x0 writes are dropped at capture so the write port never targets x0.
    if (accept) begin
      we_d    = rf_we_i & (|rf_waddr_i);
      waddr_d = rf_waddr_i;
      wdata_d = rf_wdata_i;
      cnt_d   = '0;
      state_d = instr_is_load_i ? WB_LOAD : WB_RESULT;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WB_IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_no_en_when_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    !(en_wb_i && !ready_wb_o))
    else $error("en_wb_i asserted while ready_wb_o is low");
`endif

endmodule

// File: tb/tb_ibex_wb_result_stage.sv
// Scoreboard bench for ibex_wb_result_stage: directed scenarios followed by random traffic,
// checked every cycle against a queue-based model of held instructions.
module tb_ibex_wb_result_stage;

  localparam int unsigned TO = 6;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_wb_i = 1'b0;
  logic        instr_is_load_i = 1'b0;
  logic        rf_we_i = 1'b0;
  logic [4:0]  rf_waddr_i = '0;
  logic [31:0] rf_wdata_i = '0;
  logic        ready_wb_o;
  logic        lsu_resp_valid_i = 1'b0;
  logic [31:0] lsu_rdata_i = '0;
  logic        lsu_resp_err_i = 1'b0;
  logic        rf_we_wb_o;
  logic [4:0]  rf_waddr_wb_o;
  logic [31:0] rf_wdata_wb_o;
  logic        fwd_valid_o;
  logic        instr_done_wb_o;
  logic        load_err_o;
  logic        load_timeout_o;

  ibex_wb_result_stage #(.LsuTimeout(TO), .CntWidth(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_wb_i(en_wb_i), .instr_is_load_i(instr_is_load_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .rf_wdata_i(rf_wdata_i), .ready_wb_o(ready_wb_o),
    .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_rdata_i(lsu_rdata_i), .lsu_resp_err_i(lsu_resp_err_i),
    .rf_we_wb_o(rf_we_wb_o), .rf_waddr_wb_o(rf_waddr_wb_o), .rf_wdata_wb_o(rf_wdata_wb_o),
    .fwd_valid_o(fwd_valid_o), .instr_done_wb_o(instr_done_wb_o), .load_err_o(load_err_o),
    .load_timeout_o(load_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          we;
    logic [4:0]  a;
    logic [31:0] d;
    bit          ld;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   load_age = 0;
  bit   chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; en is only raised when the stage reports ready.
  task automatic cyc(input bit want_en, input bit ld, input bit we, input logic [4:0] a,
                     input logic [31:0] d, input bit rv, input logic [31:0] rd, input bit er);
    bit   acc;
    exp_t e;
    @(negedge clk_i);
    lsu_resp_valid_i = rv;
    lsu_rdata_i      = rd;
    lsu_resp_err_i   = er;
    #1;
    acc             = want_en && (ready_wb_o === 1'b1);
    en_wb_i         = acc;
    instr_is_load_i = ld;
    rf_we_i         = we;
    rf_waddr_i      = a;
    rf_wdata_i      = d;
    @(posedge clk_i);
    if (acc) begin
      e.we = we && (a != 5'd0);
      e.a  = a;
      e.d  = d;
      e.ld = ld;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 5'd0, 32'h0, 0, 32'h0, 0);
  endtask

  // Per-cycle model: the head of the queue is the held instruction.
  always begin
    @(negedge clk_i);
    #4;
    if (chk_en) begin
      bit          has, e_done, e_we, e_err, e_to, e_rdy, retire;
      logic [31:0] e_data;
      exp_t        h;
      has    = (exp_q.size() != 0);
      e_done = 0; e_we = 0; e_err = 0; e_to = 0; e_rdy = 1; retire = 0;
      e_data = 32'h0;
      if (has) begin
        h = exp_q[0];
        if (!h.ld) begin
          retire = 1; e_we = h.we; e_data = h.d;
        end else if (lsu_resp_valid_i) begin
          retire = 1; e_we = h.we && !lsu_resp_err_i; e_err = lsu_resp_err_i; e_data = lsu_rdata_i;
        end else if (load_age + 1 == int'(TO)) begin
          retire = 1; e_to = 1;
        end else begin
          e_rdy = 0;
        end
        e_done = retire;
        chk("waddr", {27'b0, rf_waddr_wb_o}, {27'b0, h.a});
      end
      chk("done", {31'b0, instr_done_wb_o}, {31'b0, e_done});
      chk("we", {31'b0, rf_we_wb_o}, {31'b0, e_we});
      chk("fwd", {31'b0, fwd_valid_o}, {31'b0, e_we});
      chk("load_err", {31'b0, load_err_o}, {31'b0, e_err});
      chk("timeout", {31'b0, load_timeout_o}, {31'b0, e_to});
      chk("ready", {31'b0, ready_wb_o}, {31'b0, e_rdy});
      if (e_we) chk("wdata", rf_wdata_wb_o, e_data);
      if (retire) begin
        void'(exp_q.pop_front());
        load_age = 0;
      end else if (has) begin
        load_age++;
      end
    end
  end

  initial begin
    #12;
    chk("rst_ready", {31'b0, ready_wb_o}, 32'd1);
    chk("rst_outs", {rf_we_wb_o, fwd_valid_o, instr_done_wb_o, load_err_o, load_timeout_o},
        32'd0);
    chk("rst_data", rf_wdata_wb_o, 32'h0);
    @(negedge clk_i);
    rst_i  = 1'b0;
    chk_en = 1'b1;

    cyc(1, 0, 1, 5'd5, 32'hDEADBEEF, 0, 32'h0, 0);
    idle(2);
    cyc(1, 0, 1, 5'd1, 32'h11111111, 0, 32'h0, 0);
    cyc(1, 0, 1, 5'd2, 32'h22222222, 1, 32'hBAD0BAD0, 0);
    cyc(1, 0, 1, 5'd3, 32'h33333333, 0, 32'h0, 0);
    idle(2);
    cyc(1, 1, 1, 5'd7, 32'hFFFFFFFF, 0, 32'h0, 0);
    idle(3);
    cyc(0, 0, 0, 5'd0, 32'h0, 1, 32'h12345678, 0);
    idle(1);
    cyc(1, 1, 1, 5'd9, 32'h0, 0, 32'h0, 0);
    cyc(0, 0, 0, 5'd0, 32'h0, 1, 32'hCAFEF00D, 1);
    idle(1);
    cyc(1, 1, 1, 5'd4, 32'h0, 0, 32'h0, 0);
    idle(int'(TO));
    cyc(0, 0, 0, 5'd0, 32'h0, 1, 32'hABCDABCD, 0);
    idle(1);
    cyc(1, 0, 1, 5'd0, 32'h55555555, 0, 32'h0, 0);
    idle(1);

    cyc(1, 1, 1, 5'd12, 32'h0, 0, 32'h0, 0);
    idle(1);
    chk_en = 1'b0;
    @(negedge clk_i);
    lsu_rdata_i = 32'h77777777;
    #2 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("midrst_ready", {31'b0, ready_wb_o}, 32'd1);
    chk("midrst_outs", {rf_we_wb_o, fwd_valid_o, instr_done_wb_o, load_err_o, load_timeout_o},
        32'd0);
    chk("midrst_data", rf_wdata_wb_o, 32'h0);
    chk("midrst_addr", {27'b0, rf_waddr_wb_o}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_q.delete();
    load_age = 0;
    chk_en   = 1'b1;
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 8) != 0,
          5'($urandom % 32), $urandom, ($urandom % 3) == 0, $urandom, ($urandom % 6) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 5'd0, 32'h0, 1, 32'h0, 0);
    chk("drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
